// File: rtl/mul_seq_if.sv
// Request/complete handshake between the execute stage and the sequential multiplier.
// The multiplier takes the slave side; the requester (or bench) takes the master side.
interface mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             En;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             We;

  modport master (
    output En, A, B,
    input  Hi, Lo, Busy, We
  );

  modport slave (
    input  En, A, B,
    output Hi, Lo, Busy, We
  );
endinterface

// File: rtl/mul_seq.sv
// Radix-2 shift-and-add unsigned multiplier: one product bit per cycle,
// result on Hi/Lo with a single-cycle We strobe for HI/LO write-back.
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  mul_seq_if.slave      bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH-1:0] r_p;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_we;

  // Upper half plus conditional multiplicand; the extra bit keeps the carry,
  // which the right shift then folds back into the product register.
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_p_next;

  assign w_sum    = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : '0);
  assign w_p_next = {w_sum, r_p[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in the block.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_m     <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.En) begin
            r_m     <= bus.A;
            r_p     <= {{WIDTH{1'b0}}, bus.B};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_p   <= w_p_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CNT_LAST) begin
            r_hi    <= w_p_next[2*WIDTH-1:WIDTH];
            r_lo    <= w_p_next[WIDTH-1:0];
            r_we    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // En here is deliberately ignored; a new request is taken only in IDLE.
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.Hi   = r_hi;
  assign bus.Lo   = r_lo;
  assign bus.Busy = r_busy;
  assign bus.We   = r_we;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed vector table, hand-written
// back-to-back and mid-operation reset sequences, then random operands.
module tb_mul_seq;

  localparam int W = 32;

  logic clk;
  logic rst_n;

  mul_seq_if #(.WIDTH(W)) bus ();

  mul_seq #(.WIDTH(W)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int we_count = 0;

  always @(negedge clk) if (bus.We === 1'b1) we_count++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Results of the most recent do_op call
  logic [63:0] prev_prod;
  logic [63:0] got_prod;
  int          got_lat;
  int          got_busy;
  bit          got_hold;
  logic        got_we_tail;

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit scramble);
    @(negedge clk);
    bus.En = 1'b1;
    bus.A  = a;
    bus.B  = b;
    @(posedge clk);
    #1;
    bus.En      = 1'b0;
    got_busy    = bus.Busy ? 1 : 0;
    got_hold    = 1'b1;
    got_lat     = -1;
    got_prod    = '0;
    got_we_tail = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (scramble) begin
        bus.A = $urandom;
        bus.B = $urandom;
      end
      @(posedge clk);
      #1;
      if (bus.Busy) got_busy++;
      if (bus.We) begin
        got_lat  = k;
        got_prod = {bus.Hi, bus.Lo};
        break;
      end
      if ({bus.Hi, bus.Lo} !== prev_prod) got_hold = 1'b0;
    end
    if (got_lat > 0) begin
      @(posedge clk);
      #1;
      if (bus.Busy) got_busy++;
      got_we_tail = bus.We;
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          scramble;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int w0;
    int k1, k2;
    logic [63:0] r1, r2;
    int rand_bad_lat;
    logic [31:0] ra, rb;

    vecs[0] = '{32'd3,         32'd5,         1'b0, 32'h0000_0000, 32'h0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{32'h8000_0000, 32'd2,         1'b0, 32'h0000_0001, 32'h0000_0000};
    vecs[3] = '{32'd0,         32'h1234_5678, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{32'd7,         32'd6,         1'b1, 32'h0000_0000, 32'd42};

    bus.En = 1'b0;
    bus.A  = '0;
    bus.B  = '0;
    rst_n  = 1'b0;
    prev_prod = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_hilo", {bus.Hi, bus.Lo}, 64'd0);
    check("reset_busy_we", {62'd0, bus.Busy, bus.We}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: product, latency, busy span, hold, single-cycle We
    foreach (vecs[i]) begin
      w0 = we_count;
      do_op(vecs[i].a, vecs[i].b, vecs[i].scramble);
      check($sformatf("vec%0d_prod", i), got_prod, {vecs[i].hi, vecs[i].lo});
      check($sformatf("vec%0d_latency", i), 64'(got_lat), 64'd32);
      check($sformatf("vec%0d_busy_cycles", i), 64'(got_busy), 64'd33);
      check($sformatf("vec%0d_hold", i), 64'(got_hold), 64'd1);
      check($sformatf("vec%0d_we_tail", i), 64'(got_we_tail), 64'd0);
      check($sformatf("vec%0d_we_count", i), 64'(we_count - w0), 64'd1);
      prev_prod = {vecs[i].hi, vecs[i].lo};
    end

    // Back-to-back with En held: DONE must not accept, next accept one edge later
    @(negedge clk);
    bus.En = 1'b1;
    bus.A  = 32'd10;
    bus.B  = 32'd10;
    @(posedge clk);
    #1;
    bus.A = 32'h0001_0000;
    bus.B = 32'h0001_0000;
    k1 = -1;
    k2 = -1;
    r1 = '0;
    r2 = '0;
    for (int k = 1; k <= 120; k++) begin
      @(posedge clk);
      #1;
      if (bus.We) begin
        if (k1 < 0) begin
          k1 = k;
          r1 = {bus.Hi, bus.Lo};
        end else begin
          k2 = k;
          r2 = {bus.Hi, bus.Lo};
          bus.En = 1'b0;
          break;
        end
      end
    end
    bus.En = 1'b0;
    check("b2b_first_prod", r1, 64'd100);
    check("b2b_second_prod", r2, 64'h0000_0001_0000_0000);
    check("b2b_first_latency", 64'(k1), 64'd32);
    check("b2b_spacing", 64'(k2 - k1), 64'd34);
    prev_prod = r2;
    repeat (2) @(posedge clk);

    // Asynchronous reset mid-RUN discards the operation
    @(negedge clk);
    bus.En = 1'b1;
    bus.A  = 32'd9;
    bus.B  = 32'd9;
    @(posedge clk);
    #1;
    bus.En = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    w0 = we_count;
    rst_n = 1'b0;
    #1;
    check("midreset_hilo", {bus.Hi, bus.Lo}, 64'd0);
    check("midreset_busy_we", {62'd0, bus.Busy, bus.We}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    check("midreset_no_we", 64'(we_count - w0), 64'd0);
    prev_prod = '0;
    do_op(32'd2, 32'd4, 1'b0);
    check("postreset_prod", got_prod, 64'd8);
    check("postreset_latency", 64'(got_lat), 64'd32);
    prev_prod = got_prod;

    // Random operands against the arithmetic product
    w0 = we_count;
    rand_bad_lat = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 97 == 0) ra = 32'hFFFF_FFFF;
      if (i % 89 == 0) rb = 32'hFFFF_FFFF;
      do_op(ra, rb, (i % 3) == 0);
      check("rand_prod", got_prod, 64'(ra) * 64'(rb));
      if (got_lat != 32 || !got_hold) rand_bad_lat++;
      prev_prod = 64'(ra) * 64'(rb);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    check("rand_timing_hold_errors", 64'(rand_bad_lat), 64'd0);
    check("rand_we_count", 64'(we_count - w0), 64'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
